// File: rtl/matrix_loader.sv
// Matrix loader: collects a row-major 8x8 matrix of nibbles, hands it to the
// determinant core through a Start/Ack handshake, times the computation and
// holds the captured determinant until the result is released with Clear.
module matrix_loader (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         In_valid,
  input  logic [3:0]   In_data,
  output logic         In_ready,
  input  logic         Clear,
  input  logic         Core_enter,
  input  logic         Core_done,
  input  logic [31:0]  Det_in,
  output logic         Start,
  output logic         Ack,
  output logic [255:0] input_arr_flat,
  output logic [2:0]   Row,
  output logic [2:0]   Col,
  output logic [31:0]  Det_out,
  output logic         Det_neg,
  output logic         Det_valid,
  output logic [23:0]  Cycles,
  output logic         q_Fill,
  output logic         q_Arm,
  output logic         q_Wait,
  output logic         q_Ack,
  output logic         q_Result
);

  localparam int unsigned DW  = 4;
  localparam int unsigned NE  = 64;
  localparam int unsigned KW  = 6;
  localparam int unsigned FW  = 256;
  localparam int unsigned CW  = 24;
  localparam int unsigned DTW = 32;

  typedef enum logic [4:0] {
    S_FILL   = 5'b00001,
    S_ARM    = 5'b00010,
    S_WAIT   = 5'b00100,
    S_ACK    = 5'b01000,
    S_RESULT = 5'b10000
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [KW-1:0] k;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_FILL;
    else       state <= state_next;
  end

  // Next-state logic; Clear only matters in FILL and RESULT
  always_comb begin
    state_next = state;
    case (state)
      S_FILL:   if (!Clear && In_valid && (k == KW'(NE - 1))) state_next = S_ARM;
      S_ARM:    if (Core_enter) state_next = S_WAIT;
      S_WAIT:   if (Core_done)  state_next = S_ACK;
      S_ACK:    state_next = S_RESULT;
      S_RESULT: if (Clear)      state_next = S_FILL;
      default:  state_next = S_FILL;
    endcase
  end

  // Matrix storage, load index, latency counter and determinant capture
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      k              <= '0;
      input_arr_flat <= '0;
      Det_out        <= '0;
      Cycles         <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (Clear) begin
            k              <= '0;
            input_arr_flat <= '0;
          end else if (In_valid) begin
            input_arr_flat[{k, 2'b00} +: DW] <= In_data;
            k                                <= k + KW'(1);
          end
        end
        S_ARM: begin
          if (Core_enter) Cycles <= '0;
        end
        S_WAIT: begin
          if (Core_done)        Det_out <= Det_in;
          else if (Cycles != '1) Cycles <= Cycles + CW'(1);
        end
        S_RESULT: begin
          if (Clear) begin
            k              <= '0;
            input_arr_flat <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from flops: one-hot state bits, index and capture
  assign q_Fill    = state[0];
  assign q_Arm     = state[1];
  assign q_Wait    = state[2];
  assign q_Ack     = state[3];
  assign q_Result  = state[4];
  assign In_ready  = state[0];
  assign Start     = state[1];
  assign Ack       = state[3];
  assign Det_valid = state[4];
  assign Row       = k[5:3];
  assign Col       = k[2:0];
  assign Det_neg   = Det_out[DTW-1];

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader with a simple determinant core model.
module tb_matrix_loader;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         In_valid;
  logic [3:0]   In_data;
  logic         In_ready;
  logic         Clear;
  logic         Core_enter;
  logic         Core_done;
  logic [31:0]  Det_in;
  logic         Start;
  logic         Ack;
  logic [255:0] input_arr_flat;
  logic [2:0]   Row;
  logic [2:0]   Col;
  logic [31:0]  Det_out;
  logic         Det_neg;
  logic         Det_valid;
  logic [23:0]  Cycles;
  logic         q_Fill, q_Arm, q_Wait, q_Ack, q_Result;

  int total = 0;
  int bad   = 0;
  logic [3:0]   mat [64];
  logic [255:0] exp_flat;

  matrix_loader dut (
    .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .In_data(In_data),
    .In_ready(In_ready), .Clear(Clear), .Core_enter(Core_enter),
    .Core_done(Core_done), .Det_in(Det_in), .Start(Start), .Ack(Ack),
    .input_arr_flat(input_arr_flat), .Row(Row), .Col(Col),
    .Det_out(Det_out), .Det_neg(Det_neg), .Det_valid(Det_valid),
    .Cycles(Cycles), .q_Fill(q_Fill), .q_Arm(q_Arm), .q_Wait(q_Wait),
    .q_Ack(q_Ack), .q_Result(q_Result)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] flat_of_mat();
    logic [255:0] f = '0;
    for (int i = 0; i < 64; i++) f[i*4 +: 4] = mat[i];
    return f;
  endfunction

  // Offer all 64 entries back to back, starting at a negedge in FILL
  task automatic load_matrix();
    for (int i = 0; i < 64; i++) begin
      In_valid = 1'b1;
      In_data  = mat[i];
      @(negedge Clk);
    end
    In_valid = 1'b0;
    exp_flat = flat_of_mat();
    check("arm_state", {q_Fill, q_Arm, q_Wait, q_Ack, q_Result}, 5'b01000);
    check("flat_loaded", input_arr_flat, exp_flat);
  endtask

  // Core model: enter on Start, report done after n WAIT cycles
  task automatic run_core(input int n, input logic [31:0] det, input int clear_at);
    check("start_hi", Start, 1'b1);
    check("ready_lo_arm", In_ready, 1'b0);
    Core_enter = 1'b1;
    Det_in     = det;
    @(negedge Clk);
    Core_enter = 1'b0;
    check("wait_state", q_Wait, 1'b1);
    check("start_lo", Start, 1'b0);
    check("cycles_zero", Cycles, 24'd0);
    for (int i = 0; i < n; i++) begin
      Clear = (i == clear_at);
      @(negedge Clk);
    end
    Clear = 1'b0;
    check("still_wait", q_Wait, 1'b1);
    check("cycles_n", Cycles, 24'(n));
    Core_done = 1'b1;
    @(negedge Clk);
    Core_done = 1'b0;
    check("ack_hi", Ack, 1'b1);
    check("ack_state", q_Ack, 1'b1);
    check("det_cap", Det_out, det);
    @(negedge Clk);
    check("ack_lo", Ack, 1'b0);
    check("result_state", q_Result, 1'b1);
    check("det_valid", Det_valid, 1'b1);
    check("det_neg", Det_neg, det[31]);
    check("cycles_hold", Cycles, 24'(n));
    check("flat_hold", input_arr_flat, exp_flat);
    @(negedge Clk);
    check("det_hold", Det_out, det);
  endtask

  // Release the result with Clear and confirm the loader is empty again
  task automatic release_result();
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    check("rel_fill", q_Fill, 1'b1);
    check("rel_valid", Det_valid, 1'b0);
    check("rel_rowcol", {Row, Col}, 6'd0);
    check("rel_flat", input_arr_flat, 256'd0);
    check("rel_ready", In_ready, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, {q_Fill, q_Arm, q_Wait, q_Ack, q_Result}, 5'b10000);
    check({tag, "_rowcol"}, {Row, Col}, 6'd0);
    check({tag, "_flat"}, input_arr_flat, 256'd0);
    check({tag, "_det"}, {Det_out, Det_neg}, 33'd0);
    check({tag, "_cycles"}, Cycles, 24'd0);
    check({tag, "_hs"}, {Start, Ack, Det_valid, In_ready}, 4'b0001);
  endtask

  int  xfers;
  logic rdy;

  initial begin
    Reset = 1'b1; In_valid = 1'b0; In_data = '0; Clear = 1'b0;
    Core_enter = 1'b0; Core_done = 1'b0; Det_in = '0;
    #12;
    check_reset_values("rst");
    @(negedge Clk);
    Reset = 1'b0;

    // Identity matrix, core returns 1
    for (int i = 0; i < 64; i++) mat[i] = (i % 9 == 0) ? 4'd1 : 4'd0;
    load_matrix();
    check("ident_k9", input_arr_flat[39:36], 4'd1);
    check("ident_k1", input_arr_flat[7:4], 4'd0);
    check("ident_k63", input_arr_flat[255:252], 4'd1);
    run_core(5, 32'd1, -1);
    release_result();

    // Backpressure: In_valid held for 70 cycles
    for (int i = 0; i < 64; i++) mat[i] = 4'(i) ^ 4'h5;
    xfers = 0;
    for (int c = 0; c < 70; c++) begin
      In_valid = 1'b1;
      In_data  = (xfers < 64) ? mat[xfers] : 4'hA;
      rdy      = In_ready;
      if (rdy && xfers == 63) check("rowcol_77", {Row, Col}, 6'b111111);
      @(negedge Clk);
      if (rdy) begin
        xfers++;
        if (xfers == 64) check("ready_drop", In_ready, 1'b0);
      end
    end
    In_valid = 1'b0;
    exp_flat = flat_of_mat();
    check("bp_xfers", xfers, 64);
    check("bp_flat", input_arr_flat, exp_flat);
    run_core(3, 32'h12345678, -1);
    release_result();

    // Clear after 37 transfers, with a nibble offered in the Clear cycle
    for (int i = 0; i < 37; i++) begin
      In_valid = 1'b1; In_data = 4'h7;
      @(negedge Clk);
    end
    check("pre_clr_rowcol", {Row, Col}, 6'd37);
    Clear = 1'b1; In_valid = 1'b1; In_data = 4'hF;
    @(negedge Clk);
    Clear = 1'b0; In_valid = 1'b0;
    check("clr_rowcol", {Row, Col}, 6'd0);
    check("clr_flat", input_arr_flat, 256'd0);
    check("clr_fill", q_Fill, 1'b1);
    In_valid = 1'b1; In_data = 4'h9;
    @(negedge Clk);
    In_valid = 1'b0;
    check("after_clr_k0", input_arr_flat, 256'h9);
    check("after_clr_col", {Row, Col}, 6'd1);
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;

    // Long compute with a Clear pulse that must be ignored
    for (int i = 0; i < 64; i++) mat[i] = 4'(i * 7 + 3);
    load_matrix();
    run_core(1000, 32'hFFFFFF85, 500);
    release_result();

    // Reset in the middle of WAIT, then a normal run
    for (int i = 0; i < 64; i++) mat[i] = 4'(63 - i);
    load_matrix();
    Core_enter = 1'b1;
    @(negedge Clk);
    Core_enter = 1'b0;
    check("pre_rst_wait", q_Wait, 1'b1);
    repeat (10) @(negedge Clk);
    check("pre_rst_cycles", Cycles, 24'd10);
    #2 Reset = 1'b1;
    #1 check_reset_values("mid_rst");
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 64; i++) mat[i] = (i % 9 == 0) ? 4'd2 : 4'd1;
    load_matrix();
    check("post_rst_k0", input_arr_flat[3:0], 4'd2);
    run_core(7, 32'hFFFFFFFE, -1);
    release_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have port Clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port In_valid, input, 1, nibble on In_data is offered.
REQ-004 SHALL have port In_data, input, 4, unsigned matrix entry, row-major order.
REQ-005 SHALL have port In_ready, output, 1, loader accepts a nibble this cycle.
REQ-006 SHALL have port Clear, input, 1, discards loaded entries or releases the result.
REQ-007 SHALL have port Core_enter, input, 1, determinant core is in ENTER (q_Enter).
REQ-008 SHALL have port Core_done, input, 1, determinant core is in DONE (q_Done).
REQ-009 SHALL have port Det_in, input, 32, determinant from the core, two's complement.
REQ-010 SHALL have ports Start and Ack, output, 1 each, handshake to the core.
REQ-011 SHALL have port input_arr_flat, output, 256, entry k in bits [4k+3:4k], k = row*8+col.
REQ-012 SHALL have ports Row and Col, output, 3 each, position of the next entry to load.
REQ-013 SHALL have port Det_out, output, 32, captured determinant; Det_neg, output, 1, equal to Det_out[31].
REQ-014 SHALL have port Det_valid, output, 1, Det_out holds a result.
REQ-015 SHALL have port Cycles, output, 24, core compute latency in clock cycles.
REQ-016 SHALL have ports q_Fill, q_Arm, q_Wait, q_Ack, q_Result, output, 1 each, one-hot state.

Function
REQ-017 SHALL implement one-hot FSM FILL -> ARM -> WAIT -> ACK -> RESULT -> FILL.
REQ-018 SHALL, in FILL: In_ready=1; a nibble transfers on a cycle where In_valid=1 and In_ready=1.
- Write: In_data -> input_arr_flat[4k+3:4k], k = {Row,Col}.
- Index: k increments by 1.
REQ-019 SHALL go to ARM on the edge accepting entry 63; In_ready=0 in every state except FILL.
REQ-020 SHALL, in FILL with Clear=1: k=0 and input_arr_flat=0; Clear has priority over a simultaneous transfer, whose nibble is dropped.
REQ-021 SHALL, in ARM: Start=1; go to WAIT on the edge where Start=1 and Core_enter=1; Start=0 in all other states.
REQ-022 SHALL, on the ARM->WAIT edge: clear Cycles to 0.
REQ-023 SHALL, in WAIT: increment Cycles each cycle Core_done=0, saturating at 24'hFFFFFF.
REQ-024 SHALL, in WAIT with Core_done=1: capture Det_in into Det_out on that edge and go to ACK.
REQ-025 SHALL, in ACK: Ack=1 for exactly one cycle, then go to RESULT; Ack=0 in all other states.
REQ-026 SHALL, in RESULT: Det_valid=1; Det_out, Cycles and input_arr_flat held.
REQ-027 SHALL, in RESULT with Clear=1: go to FILL with k=0 and input_arr_flat=0, and set Det_valid=0.
REQ-028 SHALL ignore Clear in ARM, WAIT and ACK; the core cannot be aborted.
REQ-029 SHALL hold input_arr_flat stable from ARM through RESULT.
REQ-030 SHALL drive all outputs from registers only; no combinational input-to-output paths.

Reset
REQ-031 SHALL, on Reset=1, asynchronously set:
- state FILL (q_Fill=1, other q_* 0);
- k=0, input_arr_flat=0, Det_out=0, Cycles=0;
- Start=0, Ack=0, Det_valid=0.
REQ-032 SHALL apply REQ-031 from any state, including mid-WAIT; the next accepted nibble goes to k=0.

Verification
REQ-033 SHALL cover identity load: 64 nibbles, 1 at k=0,9,18,...,63 and 0 elsewhere, with a core model returning 1.
- input_arr_flat has 1s only at those nibbles.
- Start is seen, then Ack pulses one cycle.
- Det_out=1, Det_neg=0, Det_valid=1.
REQ-034 SHALL cover backpressure: In_valid held high for 70 cycles.
- Exactly 64 transfers.
- In_ready=0 from the cycle after entry 63 is accepted.
- Row/Col read 7/7 before the last transfer.
REQ-035 SHALL cover Clear after 37 transfers, asserted together with In_valid=1.
- k=0 and input_arr_flat=0; the nibble offered in the Clear cycle is dropped.
REQ-036 SHALL cover latency and Clear during compute: core model asserts Core_done after 1000 WAIT cycles, Clear pulsed mid-WAIT.
- Cycles=1000, Det_out=Det_in (e.g. 32'hFFFFFF85, Det_neg=1).
- The Clear pulse has no effect.
REQ-037 SHALL cover Reset mid-WAIT.
- All outputs reach their REQ-031 values immediately.
- A following full load and compute completes normally.
